// File: rtl/pll_cfg_ctrl_pkg.sv
// pll_cfg_ctrl_pkg: shared types for the PLL configuration/lock sequencer.
package pll_cfg_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RESET     = 3'd1,
      WAIT_LOCK = 3'd2,
      LOCKED    = 3'd3,
      ERROR     = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      TIMEOUT = 2'd1,
      LOSS    = 2'd2,
      BADCFG  = 2'd3
   } err_code_e;

   // A divider of zero would stall the PLL, so such a request is refused.
   function automatic logic cfg_is_bad(input logic ref_zero, input logic fb_zero);
      return ref_zero || fb_zero;
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: multi-flop synchronizer bringing the raw PLL lock into the
// controller clock domain. Clears to 0 on reset so lock is never assumed.
module pll_lock_sync
   import pll_cfg_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic async_i,
   output logic sync_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   // shift the raw lock one stage per clock
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
   end

   // synchronizer flops, cleared asynchronously
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_cfg_ctrl.sv
// pll_cfg_ctrl: accepts divider requests, holds the PLL in reset while new
// dividers are applied, then waits for a debounced lock with a timeout.
// Optional build macro PLL_CFG_CTRL_AUTO_RELOCK_EN: on loss of lock, flag
// LOSS and re-run the reset/lock sequence with the same dividers instead of
// stopping in ERROR.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | out of reset, no configuration applied yet, ready
// RESET     | PLL held in reset for RST_CYCLES with new dividers applied
// WAIT_LOCK | PLL released, counting stable lock cycles and timeout
// LOCKED    | debounced lock reported, ready for a new request
// ERROR     | bad request, timeout or loss of lock; PLL held in reset
module pll_cfg_ctrl
   import pll_cfg_ctrl_pkg::*;
#(
   parameter int REF_DEV_WIDTH = 4,
   parameter int FB_DEV_WIDTH  = 8,
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_STABLE   = 8,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     clk_i,
   input  logic                     arst_i,
   input  logic                     cfg_valid_i,
   output logic                     cfg_ready_o,
   input  logic [REF_DEV_WIDTH-1:0] cfg_refdiv_i,
   input  logic [FB_DEV_WIDTH-1:0]  cfg_fbdiv_i,
   output logic                     pll_arst_no,
   output logic [REF_DEV_WIDTH-1:0] pll_refdiv_o,
   output logic [FB_DEV_WIDTH-1:0]  pll_fbdiv_o,
   input  logic                     pll_locked_i,
   output logic                     locked_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic [1:0]               err_code_o
);

   localparam logic [2:0] ST_IDLE      = IDLE;
   localparam logic [2:0] ST_RESET     = RESET;
   localparam logic [2:0] ST_WAIT_LOCK = WAIT_LOCK;
   localparam logic [2:0] ST_LOCKED    = LOCKED;
   localparam logic [2:0] ST_ERROR     = ERROR;

   localparam int RST_W = $clog2(RST_CYCLES + 1);
   localparam int STB_W = $clog2(LOCK_STABLE + 1);
   localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

   // the reset down-counter is loaded so that its zero cycle is the last low one
   localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(LOCK_STABLE);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(LOCK_TIMEOUT);

   logic [2:0]               state_q,      state_d;
   logic                     pll_arst_n_q, pll_arst_n_d;
   logic [REF_DEV_WIDTH-1:0] refdiv_q,     refdiv_d;
   logic [FB_DEV_WIDTH-1:0]  fbdiv_q,      fbdiv_d;
   logic                     ready_q,      ready_d;
   logic                     locked_q,     locked_d;
   logic                     busy_q,       busy_d;
   logic                     done_q,       done_d;
   logic                     err_q,        err_d;
   logic [1:0]               err_code_q,   err_code_d;
   logic [RST_W-1:0]         rst_cnt_q,    rst_cnt_d;
   logic [STB_W-1:0]         stable_q,     stable_d;
   logic [TMO_W-1:0]         tmo_q,        tmo_d;

   logic lock_sync;
   logic accept;
   logic bad_cfg;
   logic [STB_W-1:0] stable_inc;
   logic [TMO_W-1:0] tmo_inc;

   pll_lock_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .async_i (pll_locked_i),
      .sync_o  (lock_sync)
   );

   // sequencing: request accept, reset hold, lock debounce/timeout, loss handling
   always_comb begin
      state_d      = state_q;
      pll_arst_n_d = pll_arst_n_q;
      refdiv_d     = refdiv_q;
      fbdiv_d      = fbdiv_q;
      locked_d     = locked_q;
      done_d       = 1'b0;
      err_d        = err_q;
      err_code_d   = err_code_q;
      rst_cnt_d    = rst_cnt_q;
      stable_d     = stable_q;
      tmo_d        = tmo_q;

      accept     = cfg_valid_i && ready_q;
      bad_cfg    = cfg_is_bad(cfg_refdiv_i == '0, cfg_fbdiv_i == '0);
      stable_inc = (stable_q == STB_MAX) ? stable_q : stable_q + STB_W'(1);
      tmo_inc    = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);

      if (accept) begin
         locked_d     = 1'b0;
         pll_arst_n_d = 1'b0;
         if (bad_cfg) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = BADCFG;
            done_d     = 1'b1;
         end else begin
            // dividers move only while the PLL is being forced into reset
            state_d    = ST_RESET;
            refdiv_d   = cfg_refdiv_i;
            fbdiv_d    = cfg_fbdiv_i;
            err_d      = 1'b0;
            err_code_d = NONE;
            rst_cnt_d  = RST_LOAD;
         end
      end else begin
         case (state_q)
            ST_RESET: begin
               if (rst_cnt_q == '0) begin
                  state_d      = ST_WAIT_LOCK;
                  pll_arst_n_d = 1'b1;
                  stable_d     = '0;
                  tmo_d        = '0;
               end else begin
                  rst_cnt_d = rst_cnt_q - RST_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               stable_d = lock_sync ? stable_inc : '0;
               tmo_d    = tmo_inc;
               // lock completion takes priority over a coincident timeout
               if (stable_d == STB_MAX) begin
                  state_d    = ST_LOCKED;
                  locked_d   = 1'b1;
                  done_d     = 1'b1;
                  err_code_d = NONE;
               end else if (tmo_d == TMO_MAX) begin
                  state_d      = ST_ERROR;
                  err_d        = 1'b1;
                  err_code_d   = TIMEOUT;
                  pll_arst_n_d = 1'b0;
                  done_d       = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (!lock_sync) begin
                  locked_d     = 1'b0;
                  err_code_d   = LOSS;
                  pll_arst_n_d = 1'b0;
`ifdef PLL_CFG_CTRL_AUTO_RELOCK_EN
                  state_d   = ST_RESET;
                  rst_cnt_d = RST_LOAD;
`else
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
`endif
               end
            end
            default: begin
            end
         endcase
      end

      busy_d  = (state_d == ST_RESET) || (state_d == ST_WAIT_LOCK);
      ready_d = (state_d == ST_IDLE) || (state_d == ST_LOCKED) || (state_d == ST_ERROR);
   end

   // state and registered outputs, cleared asynchronously
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q      <= ST_IDLE;
         pll_arst_n_q <= 1'b0;
         refdiv_q     <= '0;
         fbdiv_q      <= '0;
         ready_q      <= 1'b0;
         locked_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= NONE;
         rst_cnt_q    <= '0;
         stable_q     <= '0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         pll_arst_n_q <= pll_arst_n_d;
         refdiv_q     <= refdiv_d;
         fbdiv_q      <= fbdiv_d;
         ready_q      <= ready_d;
         locked_q     <= locked_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
         rst_cnt_q    <= rst_cnt_d;
         stable_q     <= stable_d;
         tmo_q        <= tmo_d;
      end
   end

   assign cfg_ready_o  = ready_q;
   assign pll_arst_no  = pll_arst_n_q;
   assign pll_refdiv_o = refdiv_q;
   assign pll_fbdiv_o  = fbdiv_q;
   assign locked_o     = locked_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// tb_pll_cfg_ctrl: drives divider requests and a behavioural PLL lock
// pattern, and checks phase lengths and status against timing derived
// from the sequencing rules.
module tb_pll_cfg_ctrl;

   localparam int REF_W = 4;
   localparam int FB_W  = 8;
   localparam int RST_C = 16;
   localparam int STB   = 8;
   localparam int TO    = 4096;
   localparam int SYNC  = 2;

   logic             clk_i = 1'b0;
   logic             arst_i;
   logic             cfg_valid_i;
   logic             cfg_ready_o;
   logic [REF_W-1:0] cfg_refdiv_i;
   logic [FB_W-1:0]  cfg_fbdiv_i;
   logic             pll_arst_no;
   logic [REF_W-1:0] pll_refdiv_o;
   logic [FB_W-1:0]  pll_fbdiv_o;
   logic             pll_locked_i;
   logic             locked_o;
   logic             busy_o;
   logic             done_o;
   logic             err_o;
   logic [1:0]       err_code_o;

   int n_tests;
   int n_fail;
   int exp_ref;
   int exp_fb;

   always #5 clk_i = ~clk_i;

   pll_cfg_ctrl #(
      .REF_DEV_WIDTH (REF_W),
      .FB_DEV_WIDTH  (FB_W),
      .RST_CYCLES    (RST_C),
      .LOCK_STABLE   (STB),
      .LOCK_TIMEOUT  (TO),
      .SYNC_STAGES   (SYNC)
   ) dut (
      .clk_i        (clk_i),
      .arst_i       (arst_i),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_ready_o  (cfg_ready_o),
      .cfg_refdiv_i (cfg_refdiv_i),
      .cfg_fbdiv_i  (cfg_fbdiv_i),
      .pll_arst_no  (pll_arst_no),
      .pll_refdiv_o (pll_refdiv_o),
      .pll_fbdiv_o  (pll_fbdiv_o),
      .pll_locked_i (pll_locked_i),
      .locked_o     (locked_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .err_code_o   (err_code_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic chk_out(input string tag, input int arst_n, input int busy, input int rdy,
                          input int lck, input int err, input int code, input int dn);
      chk({tag, ":arst_n"}, 32'(pll_arst_no), 32'(arst_n));
      chk({tag, ":busy"},   32'(busy_o),      32'(busy));
      chk({tag, ":ready"},  32'(cfg_ready_o), 32'(rdy));
      chk({tag, ":locked"}, 32'(locked_o),    32'(lck));
      chk({tag, ":err"},    32'(err_o),       32'(err));
      chk({tag, ":code"},   32'(err_code_o),  32'(code));
      chk({tag, ":done"},   32'(done_o),      32'(dn));
      chk({tag, ":refdiv"}, 32'(pll_refdiv_o), 32'(exp_ref));
      chk({tag, ":fbdiv"},  32'(pll_fbdiv_o),  32'(exp_fb));
   endtask

   // one-cycle request; a zero divider must be refused with dividers kept
   task automatic start_req(input int r, input int f);
      int w;
      w = 0;
      while (!cfg_ready_o && w < 64) begin
         tick();
         w++;
      end
      chk("req_ready", 32'(cfg_ready_o), 1);
      cfg_valid_i  = 1'b1;
      cfg_refdiv_i = REF_W'(r);
      cfg_fbdiv_i  = FB_W'(f);
      tick();
      cfg_valid_i  = 1'b0;
      pll_locked_i = 1'b0;
      if (r == 0 || f == 0) begin
         chk_out("badcfg", 0, 0, 1, 0, 1, 3, 1);
      end else begin
         exp_ref = r;
         exp_fb  = f;
         chk_out("accept", 0, 1, 0, 0, 0, 0, 0);
      end
   endtask

   // called in the first low cycle; measures how long the PLL is held in reset
   task automatic reset_phase(input int code);
      int low;
      low = 1;
      while (low <= RST_C + 8) begin
         tick();
         if (pll_arst_no) break;
         low++;
      end
      chk("rst_low_cycles", 32'(low), 32'(RST_C));
      chk_out("rst_end", 1, 1, 0, 0, 0, code, 0);
   endtask

   // PLL lock rises d cycles after release; if h>0 it drops for one cycle
   // after h high cycles. The last clean rise plus synchronizer and
   // debounce length gives the expected lock time.
   task automatic lock_phase(input int d, input int h);
      int n;
      int exp_n;
      exp_n = (h > 0) ? d + h + 1 + SYNC + STB : d + SYNC + STB;
      n = 0;
      while (!locked_o && n < exp_n + 64) begin
         pll_locked_i = (n >= d) && !(h > 0 && n == d + h);
         tick();
         n++;
      end
      chk("lock_latency", 32'(n), 32'(exp_n));
      chk_out("locked", 1, 0, 1, 1, 0, 0, 1);
   endtask

   task automatic timeout_phase();
      int n;
      n = 0;
      pll_locked_i = 1'b0;
      while (!done_o && n < TO + 64) begin
         tick();
         n++;
      end
      chk("timeout_cycles", 32'(n), 32'(TO));
      chk_out("timeout", 0, 0, 1, 0, 1, 1, 1);
   endtask

   task automatic loss_phase();
      int n;
      n = 0;
      pll_locked_i = 1'b0;
      while (locked_o && n < 32) begin
         tick();
         n++;
      end
      chk("loss_latency", 32'(n), 32'(SYNC + 1));
`ifdef PLL_CFG_CTRL_AUTO_RELOCK_EN
      chk_out("loss_relock", 0, 1, 0, 0, 0, 2, 0);
      reset_phase(2);
      lock_phase(int'($urandom_range(0, 30)), 0);
`else
      chk_out("loss_err", 0, 0, 1, 0, 1, 2, 1);
`endif
   endtask

   // a request held while busy is neither taken early nor dropped
   task automatic held_valid_test();
      int r2;
      int f2;
      start_req(7, 33);
      r2 = int'($urandom_range(1, 15));
      f2 = int'($urandom_range(1, 255));
      cfg_valid_i  = 1'b1;
      cfg_refdiv_i = REF_W'(r2);
      cfg_fbdiv_i  = FB_W'(f2);
      reset_phase(0);
      lock_phase(10, 0);
      tick();
      cfg_valid_i  = 1'b0;
      pll_locked_i = 1'b0;
      exp_ref = r2;
      exp_fb  = f2;
      chk_out("held_accept", 0, 1, 0, 0, 0, 0, 0);
      reset_phase(0);
      lock_phase(int'($urandom_range(0, 20)), 0);
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      exp_ref      = 0;
      exp_fb       = 0;
      arst_i       = 1'b1;
      cfg_valid_i  = 1'b0;
      cfg_refdiv_i = '0;
      cfg_fbdiv_i  = '0;
      pll_locked_i = 1'b0;

      repeat (3) tick();
      chk_out("in_reset", 0, 0, 0, 0, 0, 0, 0);
      arst_i = 1'b0;
      tick();
      chk_out("post_reset", 0, 0, 1, 0, 0, 0, 0);

      // nominal bring-up
      start_req(2, 4);
      reset_phase(0);
      lock_phase(50, 0);
      tick();
      chk("done_one_cycle", 32'(done_o), 0);
      chk("lock_hold", 32'(locked_o), 1);

      // lock never arrives
      start_req(int'($urandom_range(1, 15)), int'($urandom_range(1, 255)));
      reset_phase(0);
      timeout_phase();

      // zero divider refused, then a good request recovers
      start_req(3, 0);
      tick();
      chk("badcfg_done_pulse", 32'(done_o), 0);
      chk("badcfg_err_sticky", 32'(err_o), 1);
      start_req(1, 4);
      reset_phase(0);
      lock_phase(int'($urandom_range(0, 40)), 0);

      // glitchy lock, then loss while locked
      start_req(5, 9);
      reset_phase(0);
      lock_phase(3, 5);
      loss_phase();

      held_valid_test();

      // randomized mix of refused requests, locks and losses
      for (int i = 0; i < 10; i++) begin
         int kind;
         int r;
         int f;
         kind = int'($urandom_range(0, 2));
         r = int'($urandom_range(1, 15));
         f = int'($urandom_range(1, 255));
         if (kind == 0) begin
            if ($urandom_range(0, 1) == 0) r = 0;
            else f = 0;
            start_req(r, f);
         end else begin
            start_req(r, f);
            reset_phase(0);
            lock_phase(int'($urandom_range(0, 40)), int'($urandom_range(0, STB - 1)));
            if (kind == 2) loss_phase();
         end
      end

      // asynchronous reset in the middle of WAIT_LOCK
      start_req(6, 100);
      reset_phase(0);
      repeat (5) tick();
      #2 arst_i = 1'b1;
      #1;
      exp_ref = 0;
      exp_fb  = 0;
      chk_out("async_rst", 0, 0, 0, 0, 0, 0, 0);
      pll_locked_i = 1'b0;
      tick();
      tick();
      arst_i = 1'b0;
      tick();
      chk_out("post_async", 0, 0, 1, 0, 0, 0, 0);
      start_req(9, 200);
      reset_phase(0);
      lock_phase(int'($urandom_range(0, 40)), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pll_cfg_ctrl.md
Name: pll_cfg_ctrl

Overview:
Configuration and lock sequencer that sits directly upstream of the pll block. It accepts a divider request over a valid/ready handshake and holds the PLL in reset while the new refdiv/fbdiv values are applied. It then releases reset, waits for a debounced lock with a timeout, and reports status to the system controller. It runs on an always-on, free-running clock that is independent of the PLL output.

Parameters:
REF_DEV_WIDTH, 4, width of reference divider
FB_DEV_WIDTH, 8, width of feedback divider
RST_CYCLES, 16, cycles pll_arst_no is held low per reconfiguration (>=1)
LOCK_STABLE, 8, consecutive synchronized-lock cycles required to declare lock (>=1)
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before error (>LOCK_STABLE)
SYNC_STAGES, 2, flops in pll_locked_i synchronizer (>=2)

Ports:
clk_i  in  1  free-running controller clock
arst_i  in  1  asynchronous reset, active-high
cfg_valid_i  in  1  new configuration request
cfg_ready_o  out  1  request can be accepted
cfg_refdiv_i  in  REF_DEV_WIDTH  requested reference divider
cfg_fbdiv_i  in  FB_DEV_WIDTH  requested feedback divider
pll_arst_no  out  1  PLL reset, active-low
pll_refdiv_o  out  REF_DEV_WIDTH  divider to PLL refdiv_i
pll_fbdiv_o  out  FB_DEV_WIDTH  divider to PLL fbdiv_i
pll_locked_i  in  1  raw PLL lock, asynchronous to clk_i
locked_o  out  1  debounced lock status
busy_o  out  1  sequence in progress (RESET or WAIT_LOCK)
done_o  out  1  one-cycle pulse when a sequence ends (success or error)
err_o  out  1  sticky error, cleared on next accepted request
err_code_o  out  2  0 NONE, 1 TIMEOUT, 2 LOSS, 3 BADCFG

Behaviour:
- All outputs are registered. Asynchronous assertion of arst_i takes effect immediately. Reset values: state IDLE, pll_arst_no=0, dividers=0, cfg_ready_o=0, locked_o=0, busy_o=0, done_o=0, err_o=0, err_code_o=0.
- cfg_ready_o goes to 1 in the first cycle after arst_i deasserts.
- pll_locked_i passes through a SYNC_STAGES-flop synchronizer. All lock decisions use the synchronized value.
- cfg_ready_o=1 only in IDLE, LOCKED and ERROR. A request is accepted when cfg_valid_i && cfg_ready_o. valid held while ready=0 is not accepted and is not lost; it is accepted once ready returns.
- On accept with either divider equal to 0:
  - go to ERROR with err_code 3, err_o=1, done_o pulse next cycle.
  - pll_arst_no driven 0; divider outputs unchanged.
- On accept with both dividers nonzero:
  - next cycle: dividers latched, pll_arst_no=0, locked_o=0, err_o/err_code cleared, busy_o=1, ready=0, state RESET.
  - Divider outputs change only in the same cycle pll_arst_no falls, never while the PLL is out of reset.
- RESET: pll_arst_no stays low for exactly RST_CYCLES cycles, then goes to 1; state WAIT_LOCK.
- WAIT_LOCK:
  - A stable counter increments while the synchronized lock is 1 and clears to 0 whenever it is 0.
  - When the counter reaches LOCK_STABLE: state LOCKED, locked_o=1, busy_o=0, done_o pulse.
  - A timeout counter counts cycles in WAIT_LOCK. If it reaches LOCK_TIMEOUT without lock: state ERROR, err code 1, pll_arst_no=0, busy_o=0, done_o pulse.
  - If timeout and lock completion occur in the same cycle, lock wins.
- LOCKED: any cycle with synchronized lock=0 is a loss of lock (see Optional Feature).
- ERROR: holds outputs; waits for a new request.
- A new request accepted in LOCKED triggers a full reconfiguration; locked_o drops the cycle after accept.
- Counters are sized $clog2(max+1) and saturate; they never wrap.

Optional Feature:
PLL_CFG_CTRL_AUTO_RELOCK_EN
- Defined: on loss of lock in LOCKED, set err_code 2 (err_o stays 0) and locked_o=0, then re-enter RESET with the same dividers (busy_o=1). On successful relock err_code returns to 0.
- Undefined: on loss of lock go to ERROR, err_o=1, err_code 2, locked_o=0, pll_arst_no=0, done_o pulse.

Decomposition:
- Package pll_cfg_ctrl_pkg:
  - state enum: IDLE, RESET, WAIT_LOCK, LOCKED, ERROR.
  - err_code_e: NONE, TIMEOUT, LOSS, BADCFG, 2 bits.
- One sub-module: pll_lock_sync, a parameterized SYNC_STAGES flop synchronizer with async active-high reset to 0.

Test Plan:
1. Release arst_i with no request -> cfg_ready_o=1 at cycle 1; pll_arst_no=0, locked_o=0, err_o=0.
2. Request refdiv=2/fbdiv=4; model lock rises 50 cycles after pll_arst_no rises -> dividers 2/4; pll_arst_no low exactly 16 cycles; locked_o=1 and done_o pulse after 50+SYNC_STAGES+LOCK_STABLE cycles; busy_o low.
3. Lock never rises -> after 4096 WAIT_LOCK cycles: err_o=1, err_code=1, done_o pulse, pll_arst_no=0, ready=1.
4. Request fbdiv=0 -> ERROR, err_code=3 next cycle, no RESET phase, dividers unchanged. Then request refdiv=1/fbdiv=4 -> err cleared, normal lock.
5. Lock pattern high 5 cycles, low 1, then high -> locked_o only after 8 consecutive synchronized-high cycles. Then drop lock in LOCKED:
   - with macro: RESET re-entered, relocks, err_code 2 then 0.
   - without macro: ERROR, err_code 2.
6. Assert arst_i mid WAIT_LOCK -> all outputs at reset values immediately, without waiting for a clock edge. After release, a new request sequences normally.
